// File: rtl/qif_synaptic_current.sv
// qif_synaptic_current: leaky synaptic current integrator feeding the QIF neuron.
//
// Once per frame the current leaks by i_syn >>> DECAY_SHIFT, then the weight of
// every channel that spiked since the previous snapshot is added, one channel
// per cycle. The saturated 8-bit result appears on i_syn with a one-cycle
// i_syn_valid pulse. A frame is SNAP + N_IN x ACC + OUT = 10 cycles.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   en           run enable; a new frame starts only while high
//   spike_in     presynaptic spike lines, bit k = channel k
//   wt_valid     weight write request (wt_addr, wt_data held until accepted)
//   wt_ready     write accepted this cycle when high (low during ACC)
//   wt_addr      channel whose weight is written
//   wt_data      signed weight
//   i_syn        signed saturated synaptic current
//   i_syn_valid  one-cycle pulse when i_syn updates
//   sat_flag     sticky: some frame result was clamped
//   sat_clr      clears sat_flag (a simultaneous set wins)
module qif_synaptic_current #(
    parameter int N_IN        = 8,
    parameter int DECAY_SHIFT = 3,
    parameter int ACC_W       = 12,
    parameter int IDX_W       = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    wt_valid,
    output logic                    wt_ready,
    input  logic [IDX_W-1:0]        wt_addr,
    input  logic signed [7:0]       wt_data,
    output logic signed [7:0]       i_syn,
    output logic                    i_syn_valid,
    output logic                    sat_flag,
    input  logic                    sat_clr
);
    typedef enum logic [1:0] {IDLE, SNAP, ACC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-128);

    state_t                   state, state_nxt;
    logic [N_IN-1:0]          pending, snap;
    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic signed [7:0]        w [N_IN];

    logic signed [ACC_W-1:0]  i_ext, leak, w_ext;
    logic                     sat_hi, sat_lo;
    logic signed [7:0]        clamped;

    assign i_ext    = {{(ACC_W-8){i_syn[7]}}, i_syn};
    // Shifting the sign-extended value equals shifting the 8-bit value first.
    assign leak     = i_ext >>> DECAY_SHIFT;
    assign w_ext    = {{(ACC_W-8){w[idx][7]}}, w[idx]};
    assign sat_hi   = acc > MAX_V;
    assign sat_lo   = acc < MIN_V;
    assign clamped  = sat_hi ? 8'h7F : sat_lo ? 8'h80 : acc[7:0];
    assign wt_ready = state != ACC;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = en ? SNAP : IDLE;
            SNAP: state_nxt = ACC;
            ACC:  state_nxt = (idx == IDX_W'(N_IN - 1)) ? OUT : ACC;
            OUT:  state_nxt = en ? SNAP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            snap        <= '0;
            acc         <= '0;
            idx         <= '0;
            i_syn       <= '0;
            i_syn_valid <= 1'b0;
            sat_flag    <= 1'b0;
            for (int k = 0; k < N_IN; k++) w[k] <= '0;
        end else begin
            state       <= state_nxt;
            i_syn_valid <= state == OUT;
            // Spikes seen during SNAP go straight into snap, so pending restarts empty.
            pending     <= (state == SNAP) ? '0 : pending | spike_in;
            if (state == SNAP) begin
                snap <= pending | spike_in;
                acc  <= i_ext - leak;
                idx  <= '0;
            end
            if (state == ACC) begin
                if (snap[idx]) acc <= acc + w_ext;
                idx <= idx + 1'b1;
            end
            if (state == OUT) i_syn <= clamped;
            // A clamp in the same cycle as sat_clr keeps the flag set.
            sat_flag <= ((state == OUT) && (sat_hi || sat_lo)) || (sat_flag && !sat_clr);
            if (wt_valid && wt_ready) w[wt_addr] <= wt_data;
        end
    end
endmodule

// File: doc/qif_synaptic_current.md
Name: qif_synaptic_current

Overview:
- Upstream stage of the quadratic integrate-and-fire neuron. Turns 8 binary presynaptic spike lines into the signed 8-bit synaptic current I_syn that the neuron integrates.
- Each frame, the current leaks exponentially, then the programmable signed weights of the channels that spiked are added one channel per cycle. The result is saturated to 8 bits and presented with a one-cycle valid pulse.

Parameters:
- N_IN, 8, number of spike channels (fixed at 8 for this tapeout; channel index 3 bits).
- DECAY_SHIFT, 3, leak per frame = i_syn >>> DECAY_SHIFT (arithmetic shift).
- ACC_W, 12, signed accumulator width; must hold 127 + 8*127 with sign.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  run enable; frames start only while high
- spike_in  input  8  spike pulses, bit k = channel k; any width of pulse
- wt_valid  input  1  weight write request
- wt_ready  output  1  weight write can be accepted this cycle
- wt_addr  input  3  channel whose weight is written
- wt_data  input  8  signed weight, -128..127
- i_syn  output  8  signed synaptic current to neuron
- i_syn_valid  output  1  one-cycle pulse: i_syn updated this cycle
- sat_flag  output  1  sticky: a frame result was clamped
- sat_clr  input  1  clears sat_flag

Behaviour:
- Reset (async):
  - i_syn=0, i_syn_valid=0, sat_flag=0.
  - All 8 weights=0, pending spikes=0, acc=0, channel index=0.
  - state=IDLE.
- Spike capture:
  - Register pending[7:0] |= spike_in every cycle.
  - In SNAP, snap <= pending | spike_in, and pending is cleared. Spikes arriving in the SNAP cycle therefore land in the current frame.
  - A spike is counted at most once per frame regardless of pulse length.
- FSM states: IDLE, SNAP, ACC, OUT.
  - IDLE: wait; go to SNAP on the cycle after en is seen high.
  - SNAP: acc <= sign-extend(i_syn) - sign-extend(i_syn >>> DECAY_SHIFT); idx <= 0; go to ACC.
  - ACC: each cycle, if snap[idx] then acc <= acc + sign-extend(w[idx]); idx++. After idx=7 is processed, go to OUT. ACC lasts exactly 8 cycles.
  - OUT: i_syn <= clamp(acc, -128, 127); i_syn_valid=1 for this cycle only. If clamped, set sat_flag. Go to SNAP if en is high, else IDLE.
- Frame timing:
  - Frame period is 10 cycles with en held high.
  - i_syn changes only in OUT and holds between frames.
- Leak:
  - Arithmetic shift rounds toward -inf: negative values decay to 0; values 1..7 do not decay (for example 1 stays 1).
  - This residue is accepted and documented.
- en dropped mid-frame: the current frame completes through OUT, then the FSM goes to IDLE. Pending spikes keep accumulating while in IDLE.
- Weight interface:
  - wt_ready=0 in ACC, 1 in IDLE/SNAP/OUT.
  - Write accepted on wt_valid & wt_ready. w[wt_addr] <= wt_data at that edge, visible from the next frame's ACC.
  - wt_valid while not ready is held off; no write occurs. The requester keeps addr/data stable until accepted.
- sat_flag: set and sat_clr in the same cycle leaves it set; sat_clr alone clears it on the next edge.
- Reset mid-frame: all state returns to reset values immediately, and the partial frame is discarded.
- No combinational path from any input to any output except wt_ready, which is derived from state only.

Test Plan:
- Reset, en=1, no spikes, all weights 0 -> i_syn_valid pulses every 10 cycles, first pulse 11 cycles after en rises, i_syn=0, sat_flag=0.
- w[2]=40, w[5]=-10; one-cycle pulse on spike_in[2] and spike_in[5] -> next OUT gives i_syn=30. Next frame, no spikes -> 30-3=27, then 27-3=24.
- All weights=100, spike_in=8'hFF held one frame -> i_syn=127, sat_flag=1. Pulse sat_clr -> sat_flag=0. Set a weight to -128 on all channels with all spiking -> i_syn=-128, sat_flag=1.
- Write requests issued while the FSM is in ACC -> wt_ready=0 and no write occurs. The write completes on the first OUT/SNAP cycle, and the new weight is applied in the following frame only.
- Spike pulse on channel 0 arriving during ACC -> not in the current frame; counted exactly once in the next frame. A spike held high for 15 cycles spans two snapshots and is counted once in each.
- Assert reset during ACC with acc nonzero -> i_syn=0, i_syn_valid=0, weights=0, state IDLE. After release, the first frame result uses only post-reset spikes and weights.
